// File: rtl/sram_bridge16_if.sv
// CPU-side request bus and SRAM pad-side signals of the 16-bit SRAM bridge.
// The bridge uses the slave modport; the CPU/pad environment uses master.
interface sram_bridge16_if #(
  parameter int AW = 19
);
  logic          req;
  logic          we;
  logic          ben;
  logic [23:0]   adr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          stall;
  logic [AW-1:0] sram_a;
  logic [15:0]   sram_dout;
  logic [15:0]   sram_din;
  logic          sram_doe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_lb_n;
  logic          sram_ub_n;

  modport slave (
    input  req, we, ben, adr, wdata, sram_din,
    output rdata, stall, sram_a, sram_dout, sram_doe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );

  modport master (
    output req, we, ben, adr, wdata, sram_din,
    input  rdata, stall, sram_a, sram_dout, sram_doe,
           sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );
endinterface

// File: rtl/sram_bridge16.sv
// Runs one 32-bit CPU access as one (byte) or two (word) halfword phases on an
// asynchronous 16-bit SRAM, stalling the CPU until the access completes.
module sram_bridge16 #(
  parameter int AW   = 19,
  parameter int WAIT = 1
) (
  input logic            clk,
  input logic            rst,
  sram_bridge16_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] RD_LAST  = 5'(WAIT);
  localparam logic [4:0] WR_LAST  = 5'(WAIT + 1);
  localparam logic [4:0] STB_LAST = 5'((WAIT == 0) ? 1 : WAIT);

  state_t        state_q, state_d;
  logic          ph_q, ph_d;
  logic [4:0]    wc_q, wc_d;
  logic          ben_q, ben_d;
  logic [AW:0]   adr_q, adr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] a_q, a_d;
  logic [15:0]   dout_q, dout_d;
  logic          doe_q, doe_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          lb_n_q, lb_n_d;
  logic          ub_n_q, ub_n_d;
  logic          lane_s;
  logic          hi_s;
  logic [AW-1:0] a_nxt_s;

  // Next-state sequencing, then pad outputs derived from the state being entered
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    wc_d    = wc_q;
    ben_d   = ben_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lane_s  = ben_q ? adr_q[1] : ph_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          ben_d   = bus.ben;
          adr_d   = bus.adr[AW:0];
          wdata_d = bus.wdata;
          state_d = bus.we ? WR : RD;
          ph_d    = 1'b0;
          wc_d    = 5'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (wc_q == RD_LAST) begin
          // Byte reads clear the unused lane; word reads fill one lane per phase
          if (ben_q) begin
            rdata_d = lane_s ? {bus.sram_din, 16'h0000} : {16'h0000, bus.sram_din};
          end else if (lane_s) begin
            rdata_d[31:16] = bus.sram_din;
          end else begin
            rdata_d[15:0] = bus.sram_din;
          end
          if (ben_q || ph_q) begin
            state_d = DONE;
          end else begin
            ph_d = 1'b1;
            wc_d = 5'd0;
          end
        end else begin
          wc_d = wc_q + 5'd1;
        end
      end
      WR: begin
        if (wc_q == WR_LAST) begin
          if (ben_q || ph_q) begin
            state_d = DONE;
          end else begin
            ph_d = 1'b1;
            wc_d = 5'd0;
          end
        end else begin
          wc_d = wc_q + 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    hi_s    = ben_d ? adr_d[1] : ph_d;
    a_nxt_s = ben_d ? adr_d[AW:1] : {adr_d[AW:2], ph_d};
    a_d     = a_q;
    dout_d  = dout_q;
    doe_d   = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    ub_n_d  = 1'b1;

    case (state_d)
      RD: begin
        a_d    = a_nxt_s;
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        lb_n_d = ben_d ? adr_d[0] : 1'b0;
        ub_n_d = ben_d ? ~adr_d[0] : 1'b0;
      end
      WR: begin
        // Setup at wc=0, strobe through STB_LAST; with WAIT=0 the strobe is the final cycle
        a_d    = a_nxt_s;
        dout_d = hi_s ? wdata_d[31:16] : wdata_d[15:0];
        doe_d  = 1'b1;
        ce_n_d = 1'b0;
        we_n_d = ~((wc_d >= 5'd1) && (wc_d <= STB_LAST));
        lb_n_d = ben_d ? adr_d[0] : 1'b0;
        ub_n_d = ben_d ? ~adr_d[0] : 1'b0;
      end
      IDLE, DONE: begin
        doe_d = 1'b0;
      end
      default: begin
        doe_d = 1'b0;
      end
    endcase
  end

  // State, captured request and registered pad outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      wc_q    <= 5'd0;
      ben_q   <= 1'b0;
      adr_q   <= {(AW + 1){1'b0}};
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      a_q     <= {AW{1'b0}};
      dout_q  <= 16'h0000;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      wc_q    <= wc_d;
      ben_q   <= ben_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
    end
  end

  assign bus.stall     = rst & ((bus.req & (state_q == IDLE)) | (state_q == RD) | (state_q == WR));
  assign bus.rdata     = rdata_q;
  assign bus.sram_a    = a_q;
  assign bus.sram_dout = dout_q;
  assign bus.sram_doe  = doe_q;
  assign bus.sram_ce_n = ce_n_q;
  assign bus.sram_oe_n = oe_n_q;
  assign bus.sram_we_n = we_n_q;
  assign bus.sram_lb_n = lb_n_q;
  assign bus.sram_ub_n = ub_n_q;
endmodule

// File: tb/tb_sram_bridge16.sv
// Directed bench for sram_bridge16: WAIT=1 instance against an SRAM model,
// plus WAIT=0 and WAIT=3 instances for latency checks.
module tb_sram_bridge16;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   commits = 0;
  bit   init_done = 1'b0;
  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  sram_bridge16_if #(.AW(19)) bm ();
  sram_bridge16_if #(.AW(19)) bw0 ();
  sram_bridge16_if #(.AW(19)) bw3 ();

  sram_bridge16 #(.AW(19), .WAIT(1)) u_dut  (.clk(clk), .rst(rst), .bus(bm.slave));
  sram_bridge16 #(.AW(19), .WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bw0.slave));
  sram_bridge16 #(.AW(19), .WAIT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bw3.slave));

  assign bm.sram_din  = (!bm.sram_ce_n && !bm.sram_oe_n) ? mem[bm.sram_a[7:0]] : 16'h0000;
  assign bw0.sram_din = (!bw0.sram_ce_n && !bw0.sram_oe_n) ? (16'hA000 | {4'h0, bw0.sram_a[11:0]}) : 16'h0000;
  assign bw3.sram_din = (!bw3.sram_ce_n && !bw3.sram_oe_n) ? (16'hA000 | {4'h0, bw3.sram_a[11:0]}) : 16'h0000;

  // SRAM model: halfword i starts as 0x1000+i; a write commits per clock with we_n and ce_n low
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
      init_done <= 1'b1;
    end else if (!bm.sram_ce_n && !bm.sram_we_n) begin
      if (!bm.sram_lb_n) mem[bm.sram_a[7:0]][7:0]  <= bm.sram_dout[7:0];
      if (!bm.sram_ub_n) mem[bm.sram_a[7:0]][15:8] <= bm.sram_dout[15:8];
      commits <= commits + 1;
    end
  end

  task automatic set_bus(input logic we_i, input logic ben_i, input logic [23:0] a_i, input logic [31:0] d_i);
    bm.we = we_i;   bm.ben = ben_i;   bm.adr = a_i;   bm.wdata = d_i;
    bw0.we = we_i;  bw0.ben = ben_i;  bw0.adr = a_i;  bw0.wdata = d_i;
    bw3.we = we_i;  bw3.ben = ben_i;  bw3.adr = a_i;  bw3.wdata = d_i;
  endtask

  // Runs one access on the WAIT=1 instance; returns at the DONE-cycle sample point
  task automatic run_main(input logic we_i, input logic ben_i, input logic [23:0] a_i, input logic [31:0] d_i,
                          output int lat, output int wel, output logic [18:0] fa,
                          output logic [1:0] lanes, output logic [31:0] rd);
    int  cnt;
    bit  seen;
    set_bus(we_i, ben_i, a_i, d_i);
    bm.req = 1'b1;
    #1;
    lat = -1; cnt = 0; wel = 0; seen = 1'b0; fa = 19'h7FFFF; lanes = 2'b11;
    for (int i = 0; i < 60; i++) begin
      if (!bm.stall) begin
        lat = cnt + 1;
        break;
      end
      if (!bm.sram_ce_n && !seen) begin
        fa = bm.sram_a;
        seen = 1'b1;
      end
      if (!bm.sram_we_n) begin
        wel++;
        lanes = {bm.sram_ub_n, bm.sram_lb_n};
      end
      cnt++;
      @(negedge clk);
    end
    rd = bm.rdata;
    bm.req = 1'b0;
  endtask

  // Same as run_main for the WAIT=0 (which=0) or WAIT=3 instance
  task automatic run_w(input int which, input logic we_i, input logic [23:0] a_i,
                       output int lat, output int wel, output logic [31:0] rd);
    int   cnt;
    logic st, wen;
    set_bus(we_i, 1'b0, a_i, 32'h1111_2222);
    if (which == 0) bw0.req = 1'b1; else bw3.req = 1'b1;
    #1;
    lat = -1; cnt = 0; wel = 0;
    for (int i = 0; i < 60; i++) begin
      st  = (which == 0) ? bw0.stall : bw3.stall;
      wen = (which == 0) ? bw0.sram_we_n : bw3.sram_we_n;
      if (!st) begin
        lat = cnt + 1;
        break;
      end
      if (!wen) wel++;
      cnt++;
      @(negedge clk);
    end
    rd = (which == 0) ? bw0.rdata : bw3.rdata;
    bw0.req = 1'b0;
    bw3.req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    bm.req = 1'b1;
    #1;
    total++; if (bm.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bm.stall); end
    total++; if ({bm.sram_ce_n, bm.sram_oe_n, bm.sram_we_n, bm.sram_lb_n, bm.sram_ub_n} !== 5'b11111) begin
      bad++; $display("FAIL reset_strobes: got %b want 11111", {bm.sram_ce_n, bm.sram_oe_n, bm.sram_we_n, bm.sram_lb_n, bm.sram_ub_n}); end
    total++; if (bm.sram_doe !== 1'b0) begin bad++; $display("FAIL reset_doe: got %b want 0", bm.sram_doe); end
    total++; if (bm.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bm.rdata); end
    total++; if (bm.sram_a !== 19'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bm.sram_a); end
    @(negedge clk);
    bm.req = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bm.stall !== 1'b0) begin bad++; $display("FAIL idle_stall: got %b want 0", bm.stall); end
    total++; if ({bm.sram_ce_n, bm.sram_we_n, bm.sram_doe} !== 3'b110) begin
      bad++; $display("FAIL idle_strobes: got %b want 110", {bm.sram_ce_n, bm.sram_we_n, bm.sram_doe}); end
  endtask

  task automatic test_word_rw;
    int lat, wel; logic [18:0] fa; logic [1:0] ln; logic [31:0] rd;
    @(negedge clk);
    run_main(1'b1, 1'b0, 24'h000104, 32'hDEADBEEF, lat, wel, fa, ln, rd);
    total++; if (lat !== 8) begin bad++; $display("FAIL word_wr_latency: got %0d want 8", lat); end
    total++; if (wel !== 2) begin bad++; $display("FAIL word_wr_strobes: got %0d want 2", wel); end
    total++; if (fa !== 19'h00082) begin bad++; $display("FAIL word_wr_addr: got %h want 00082", fa); end
    total++; if (mem[8'h82] !== 16'hBEEF) begin bad++; $display("FAIL word_wr_lo: got %h want beef", mem[8'h82]); end
    total++; if (mem[8'h83] !== 16'hDEAD) begin bad++; $display("FAIL word_wr_hi: got %h want dead", mem[8'h83]); end
    @(negedge clk);
    run_main(1'b0, 1'b0, 24'h000104, 32'h0, lat, wel, fa, ln, rd);
    total++; if (lat !== 6) begin bad++; $display("FAIL word_rd_latency: got %0d want 6", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_rw;
    int lat, wel; logic [18:0] fa; logic [1:0] ln; logic [31:0] rd;
    @(negedge clk);
    run_main(1'b1, 1'b1, 24'h000107, 32'h5A000000, lat, wel, fa, ln, rd);
    total++; if (lat !== 5) begin bad++; $display("FAIL byte_wr_latency: got %0d want 5", lat); end
    total++; if (wel !== 1) begin bad++; $display("FAIL byte_wr_strobes: got %0d want 1", wel); end
    total++; if (ln !== 2'b01) begin bad++; $display("FAIL byte_wr_lanes: got ub/lb=%b want 01", ln); end
    total++; if (mem[8'h83] !== 16'h5AAD) begin bad++; $display("FAIL byte_wr_hi: got %h want 5aad", mem[8'h83]); end
    total++; if (mem[8'h82] !== 16'hBEEF) begin bad++; $display("FAIL byte_wr_other: got %h want beef", mem[8'h82]); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL byte_wr_rdata_hold: got %h want deadbeef", rd); end
    @(negedge clk);
    run_main(1'b0, 1'b1, 24'h000107, 32'h0, lat, wel, fa, ln, rd);
    total++; if (lat !== 4) begin bad++; $display("FAIL byte_rd_latency: got %0d want 4", lat); end
    total++; if (fa !== 19'h00083) begin bad++; $display("FAIL byte_rd_addr: got %h want 00083", fa); end
    total++; if (rd !== 32'h5AAD0000) begin bad++; $display("FAIL byte_rd_data: got %h want 5aad0000", rd); end
  endtask

  task automatic test_reset_mid_write;
    int c0, lat, wel; bit found; logic [18:0] fa; logic [1:0] ln; logic [31:0] rd;
    @(negedge clk);
    c0 = commits;
    set_bus(1'b1, 1'b0, 24'h000040, 32'h12345678);
    bm.req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bm.sram_we_n) begin
        found = 1'b1;
        break;
      end
    end
    #2 rst = 1'b0;
    bm.req = 1'b0;
    #1;
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_mid_strobe_seen: got %b want 1", found); end
    total++; if ({bm.sram_we_n, bm.sram_ce_n, bm.sram_doe, bm.stall} !== 4'b1100) begin
      bad++; $display("FAIL rst_mid_outputs: got we_n/ce_n/doe/stall=%b want 1100", {bm.sram_we_n, bm.sram_ce_n, bm.sram_doe, bm.stall}); end
    repeat (2) @(negedge clk);
    total++; if (commits !== c0) begin bad++; $display("FAIL rst_mid_commits: got %0d want %0d", commits, c0); end
    total++; if (mem[8'h20] !== 16'h1020) begin bad++; $display("FAIL rst_mid_mem: got %h want 1020", mem[8'h20]); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bm.stall !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: got %b want 0", bm.stall); end
    run_main(1'b0, 1'b0, 24'h000040, 32'h0, lat, wel, fa, ln, rd);
    total++; if (lat !== 6) begin bad++; $display("FAIL rst_mid_reread_latency: got %0d want 6", lat); end
    total++; if (rd !== 32'h10211020) begin bad++; $display("FAIL rst_mid_reread_data: got %h want 10211020", rd); end
  endtask

  task automatic test_wait_builds;
    int lat, wel; logic [31:0] rd;
    @(negedge clk);
    run_w(0, 1'b0, 24'h000010, lat, wel, rd);
    total++; if (lat !== 4) begin bad++; $display("FAIL w0_rd_latency: got %0d want 4", lat); end
    total++; if (rd !== 32'hA009A008) begin bad++; $display("FAIL w0_rd_data: got %h want a009a008", rd); end
    @(negedge clk);
    run_w(3, 1'b0, 24'h000010, lat, wel, rd);
    total++; if (lat !== 10) begin bad++; $display("FAIL w3_rd_latency: got %0d want 10", lat); end
    total++; if (rd !== 32'hA009A008) begin bad++; $display("FAIL w3_rd_data: got %h want a009a008", rd); end
    @(negedge clk);
    run_w(0, 1'b1, 24'h000010, lat, wel, rd);
    total++; if (lat !== 6) begin bad++; $display("FAIL w0_wr_latency: got %0d want 6", lat); end
    total++; if (wel !== 2) begin bad++; $display("FAIL w0_wr_strobes: got %0d want 2", wel); end
    @(negedge clk);
    run_w(3, 1'b1, 24'h000010, lat, wel, rd);
    total++; if (lat !== 12) begin bad++; $display("FAIL w3_wr_latency: got %0d want 12", lat); end
    total++; if (wel !== 6) begin bad++; $display("FAIL w3_wr_strobes: got %0d want 6", wel); end
  endtask

  task automatic test_wrap;
    int lat, wel; logic [18:0] fa; logic [1:0] ln; logic [31:0] rd;
    @(negedge clk);
    run_main(1'b0, 1'b0, 24'hF00000, 32'h0, lat, wel, fa, ln, rd);
    total++; if (fa !== 19'h0) begin bad++; $display("FAIL wrap_addr: got %h want 0", fa); end
    total++; if (lat !== 6) begin bad++; $display("FAIL wrap_latency: got %0d want 6", lat); end
    total++; if (rd !== 32'h10011000) begin bad++; $display("FAIL wrap_data: got %h want 10011000", rd); end
  endtask

  task automatic test_back_to_back;
    int cnt, zeros, z1, z2; logic [1:0] setup; logic [31:0] rd1;
    @(negedge clk);
    set_bus(1'b0, 1'b0, 24'h000104, 32'h0);
    bm.req = 1'b1;
    #1;
    cnt = 0; zeros = 0; z1 = -1; z2 = -1; setup = 2'b11; rd1 = 32'h0;
    for (int i = 0; i < 40; i++) begin
      cnt++;
      if (!bm.stall) begin
        zeros++;
        if (z1 < 0) begin
          z1 = cnt;
          rd1 = bm.rdata;
          set_bus(1'b1, 1'b0, 24'h000108, 32'hCAFEF00D);
        end else begin
          z2 = cnt;
          break;
        end
      end
      if (z1 > 0 && cnt == z1 + 2) setup = {bm.sram_ce_n, bm.sram_doe};
      @(negedge clk);
    end
    bm.req = 1'b0;
    total++; if (zeros !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", zeros); end
    total++; if (z1 !== 6) begin bad++; $display("FAIL b2b_first_done: got %0d want 6", z1); end
    total++; if (z2 !== 14) begin bad++; $display("FAIL b2b_second_done: got %0d want 14", z2); end
    total++; if (setup !== 2'b01) begin bad++; $display("FAIL b2b_second_start: got ce_n/doe=%b want 01", setup); end
    total++; if (rd1 !== 32'h5AADBEEF) begin bad++; $display("FAIL b2b_rd_data: got %h want 5aadbeef", rd1); end
    total++; if ({mem[8'h85], mem[8'h84]} !== 32'hCAFEF00D) begin
      bad++; $display("FAIL b2b_wr_mem: got %h want cafef00d", {mem[8'h85], mem[8'h84]}); end
    @(negedge clk);
    total++; if (bm.stall !== 1'b0) begin bad++; $display("FAIL b2b_idle_after: got %b want 0", bm.stall); end
  endtask

  initial begin
    rst = 1'b1;
    bm.req = 1'b0; bw0.req = 1'b0; bw3.req = 1'b0;
    set_bus(1'b0, 1'b0, 24'h0, 32'h0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_word_rw();
    test_byte_rw();
    test_reset_mid_write();
    test_wait_builds();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
